core_pipe_ctrl: RTL and testbench

Parametrised pipeline-control unit for the RV32 core. It replaces the fixed, hazard-free IF/ID/EX/MA/WB wiring with a scoreboard of in-flight destination registers, and generates load-use stalls, EX bubbles, branch flushes and operand-forwarding selects. It sits beside the ID stage in the core top, consuming decoded register fields and EX branch resolution, and driving the stall/flush inputs of IF and ID and the forwarding muxes in EX.

---
 rtl/core_pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_core_pipe_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_ctrl.sv
// rtl/core_pipe_ctrl.sv - RV32 pipeline control: scoreboard, load-use stall, branch flush, forwarding selects
//
// Tracks the destination registers of the NSTAGES instructions after ID
// (entry 0 = EX, 1 = MA, 2 = WB, ...) and derives from them, combinationally,
// the stall/bubble/flush controls and the EX operand-forwarding selects.
//
// Ports
//   iCLK, iRST       clock (rising edge), asynchronous active-low reset
//   iIDValid         ID holds a real instruction
//   iIDRs1/iIDRs1Used, iIDRs2/iIDRs2Used
//                    source register addresses and whether they are read
//   iIDRd/iIDWrites  destination register and whether it is written
//   iIDIsLoad        ID instruction is a load
//   iBranch          EX resolved a taken branch/jump this cycle
//   iStallD          data cache not ready; freezes the whole pipeline
//   oStallIF/oStallID  hold PC / hold the ID register
//   oBubbleEX        inject a NOP into EX
//   oFlush           kill IF/ID contents
//   oFwdA/oFwdB      operand source: 0 = register file, k = entry k-1
//   oStallCnt        saturating count of hazard-stall cycles
module core_pipe_ctrl #(
   parameter int NSTAGES    = 3,
   parameter int LOAD_LAT   = 1,
   parameter int BR_PENALTY = 2,
   parameter int CNTW       = 16,
   parameter int FW         = $clog2(NSTAGES + 1)
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iIDValid,
   input  logic [4:0]      iIDRs1,
   input  logic            iIDRs1Used,
   input  logic [4:0]      iIDRs2,
   input  logic            iIDRs2Used,
   input  logic [4:0]      iIDRd,
   input  logic            iIDWrites,
   input  logic            iIDIsLoad,
   input  logic            iBranch,
   input  logic            iStallD,
   output logic            oStallIF,
   output logic            oStallID,
   output logic            oBubbleEX,
   output logic            oFlush,
   output logic [FW-1:0]   oFwdA,
   output logic [FW-1:0]   oFwdB,
   output logic [CNTW-1:0] oStallCnt
);

   // scoreboard: one {valid, rd, isload} record per tracked stage
   logic [NSTAGES-1:0] sb_valid;
   logic [NSTAGES-1:0] sb_load;
   logic [4:0]         sb_rd [NSTAGES];

   logic [2:0]         flush_cnt;
   logic [CNTW-1:0]    stall_cnt;

   logic [NSTAGES-1:0] match_a;
   logic [NSTAGES-1:0] match_b;
   logic [NSTAGES-1:0] pend;
   logic [FW-1:0]      fwd_a;
   logic [FW-1:0]      fwd_b;
   logic               haz;
   logic               flush;
   logic               bubble;
   logic               stall;
   logic               count_en;
   logic               new_valid;

   always_comb begin
      match_a = '0;
      match_b = '0;
      pend    = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         match_a[k] = sb_valid[k] && (sb_rd[k] == iIDRs1) && (iIDRs1 != 5'd0) && iIDRs1Used;
         match_b[k] = sb_valid[k] && (sb_rd[k] == iIDRs2) && (iIDRs2 != 5'd0) && iIDRs2Used;
         // a load's data does not exist yet in the first LOAD_LAT entries
         pend[k]    = sb_load[k] && (k < LOAD_LAT);
      end
   end

   // walk from oldest to youngest so the youngest forwardable producer wins
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (match_a[k] && !pend[k]) fwd_a = FW'(k + 1);
         if (match_b[k] && !pend[k]) fwd_b = FW'(k + 1);
      end
   end

   always_comb begin
      haz       = iIDValid && ((|(match_a & pend)) || (|(match_b & pend)));
      flush     = iBranch || (flush_cnt != 3'd0);
      // flush overrides a load-use hazard; a freeze suppresses the hazard bubble
      bubble    = flush || (haz && !iStallD);
      stall     = iStallD || (haz && !flush);
      count_en  = haz && !flush && !iStallD;
      new_valid = iIDValid && iIDWrites && (iIDRd != 5'd0) && !bubble;
   end

   // outputs forced low while reset is asserted, even if inputs are active
   assign oStallIF  = iRST && stall;
   assign oStallID  = iRST && stall;
   assign oBubbleEX = iRST && bubble;
   assign oFlush    = iRST && flush;
   assign oFwdA     = iRST ? fwd_a : '0;
   assign oFwdB     = iRST ? fwd_b : '0;
   assign oStallCnt = stall_cnt;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         sb_valid  <= '0;
         sb_load   <= '0;
         for (int k = 0; k < NSTAGES; k++) sb_rd[k] <= 5'd0;
         flush_cnt <= 3'd0;
         stall_cnt <= '0;
      end else begin
         // a branch reloads the penalty even during a freeze
         if (iBranch)
            flush_cnt <= 3'(BR_PENALTY);
         else if (!iStallD && (flush_cnt != 3'd0))
            flush_cnt <= flush_cnt - 3'd1;

         if (!iStallD) begin
            // the oldest entry falls off here: WB writes the register file this edge
            sb_valid <= {sb_valid[NSTAGES-2:0], new_valid};
            sb_load  <= {sb_load[NSTAGES-2:0], iIDIsLoad};
            for (int k = NSTAGES - 1; k >= 1; k--) sb_rd[k] <= sb_rd[k-1];
            sb_rd[0] <= iIDRd;
         end

         if (count_en && (stall_cnt != {CNTW{1'b1}}))
            stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// tb/tb_core_pipe_ctrl.sv - randomized self-checking bench for core_pipe_ctrl
module tb_core_pipe_ctrl;

   localparam int NST = 3;
   localparam int LL  = 1;
   localparam int BRP = 2;
   localparam int CW  = 4;
   localparam int FWW = $clog2(NST + 1);
   localparam int SAT = (1 << CW) - 1;

   logic           iCLK = 1'b0;
   logic           iRST = 1'b0;
   logic           iIDValid, iIDRs1Used, iIDRs2Used, iIDWrites, iIDIsLoad, iBranch, iStallD;
   logic [4:0]     iIDRs1, iIDRs2, iIDRd;
   logic           oStallIF, oStallID, oBubbleEX, oFlush;
   logic [FWW-1:0] oFwdA, oFwdB;
   logic [CW-1:0]  oStallCnt;

   core_pipe_ctrl #(.NSTAGES(NST), .LOAD_LAT(LL), .BR_PENALTY(BRP), .CNTW(CW)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iIDValid(iIDValid), .iIDRs1(iIDRs1), .iIDRs1Used(iIDRs1Used),
      .iIDRs2(iIDRs2), .iIDRs2Used(iIDRs2Used), .iIDRd(iIDRd),
      .iIDWrites(iIDWrites), .iIDIsLoad(iIDIsLoad), .iBranch(iBranch), .iStallD(iStallD),
      .oStallIF(oStallIF), .oStallID(oStallID), .oBubbleEX(oBubbleEX), .oFlush(oFlush),
      .oFwdA(oFwdA), .oFwdB(oFwdB), .oStallCnt(oStallCnt)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: list of in-flight register writers, each tagged with its age
   typedef struct {
      logic [4:0] rd;
      bit         ld;
      int         age;
   } wr_t;

   wr_t fl[$];
   int  m_flush;
   int  m_cnt;
   bit  e_haz, e_flush, e_bubble, e_stall;

   function automatic int m_fwd(input logic [4:0] rs, input bit used);
      int best = -1;
      if (!used || rs == 5'd0) return 0;
      foreach (fl[i])
         if (fl[i].rd == rs && !(fl[i].ld && fl[i].age < LL))
            if (best < 0 || fl[i].age < best) best = fl[i].age;
      return (best < 0) ? 0 : best + 1;
   endfunction

   function automatic bit m_pend(input logic [4:0] rs, input bit used);
      if (!used || rs == 5'd0) return 1'b0;
      foreach (fl[i])
         if (fl[i].rd == rs && fl[i].ld && fl[i].age < LL) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      fl.delete();
      m_flush = 0;
      m_cnt   = 0;
   endtask

   task automatic compute();
      e_haz    = iIDValid && (m_pend(iIDRs1, iIDRs1Used) || m_pend(iIDRs2, iIDRs2Used));
      e_flush  = iBranch || (m_flush != 0);
      e_bubble = e_flush || (e_haz && !iStallD);
      e_stall  = iStallD || (e_haz && !e_flush);
   endtask

   task automatic check_model();
      compute();
      check("stall_if", int'(oStallIF), int'(e_stall));
      check("stall_id", int'(oStallID), int'(e_stall));
      check("bubble_ex", int'(oBubbleEX), int'(e_bubble));
      check("flush", int'(oFlush), int'(e_flush));
      if (!(e_haz && !e_flush)) begin
         check("fwd_a", int'(oFwdA), m_fwd(iIDRs1, iIDRs1Used));
         check("fwd_b", int'(oFwdB), m_fwd(iIDRs2, iIDRs2Used));
      end
      check("stall_cnt", int'(oStallCnt), m_cnt);
   endtask

   task automatic model_edge();
      compute();
      if (iBranch) m_flush = BRP;
      else if (!iStallD && m_flush > 0) m_flush--;
      if (!iStallD) begin
         if (e_haz && !e_flush && m_cnt < SAT) m_cnt++;
         foreach (fl[i]) fl[i].age++;
         for (int i = fl.size() - 1; i >= 0; i--)
            if (fl[i].age >= NST) fl.delete(i);
         if (iIDValid && iIDWrites && iIDRd != 5'd0 && !e_bubble)
            fl.push_front('{rd: iIDRd, ld: iIDIsLoad, age: 0});
      end
   endtask

   task automatic drive(input int v, input int r1, input int u1, input int r2, input int u2,
                        input int rd, input int w, input int ld, input int br, input int sd);
      iIDValid   = v[0];
      iIDRs1     = 5'(r1);
      iIDRs1Used = u1[0];
      iIDRs2     = 5'(r2);
      iIDRs2Used = u2[0];
      iIDRd      = 5'(rd);
      iIDWrites  = w[0];
      iIDIsLoad  = ld[0];
      iBranch    = br[0];
      iStallD    = sd[0];
   endtask

   task automatic cyc();
      #1;
      check_model();
      @(posedge iCLK);
      model_edge();
      @(negedge iCLK);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall_if"}, int'(oStallIF), 0);
      check({tag, "_stall_id"}, int'(oStallID), 0);
      check({tag, "_bubble"}, int'(oBubbleEX), 0);
      check({tag, "_flush"}, int'(oFlush), 0);
      check({tag, "_fwd_a"}, int'(oFwdA), 0);
      check({tag, "_fwd_b"}, int'(oFwdB), 0);
      check({tag, "_cnt"}, int'(oStallCnt), 0);
   endtask

   initial begin
      drive(1, 5, 1, 5, 1, 5, 1, 1, 1, 1);
      model_reset();
      repeat (2) @(negedge iCLK);
      #1;
      check_all_zero("reset");
      @(negedge iCLK);
      iRST = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ALU chain on x5
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cyc();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("alu_fwd1", int'(oFwdA), 1); cyc();
      #1 check("alu_fwd2", int'(oFwdA), 2); cyc();
      cyc();
      #1 check("alu_fwd_gone", int'(oFwdA), 0); cyc();

      // load-use on x7
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); cyc();
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
      #1;
      check("lu_stall_if", int'(oStallIF), 1);
      check("lu_stall_id", int'(oStallID), 1);
      check("lu_bubble", int'(oBubbleEX), 1);
      cyc();
      #1;
      check("lu_released", int'(oStallIF), 0);
      check("lu_fwd_b", int'(oFwdB), 2);
      check("lu_cnt", int'(oStallCnt), 1);
      cyc();

      // x0 is never forwarded; youngest writer wins
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cyc();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("x0_fwd", int'(oFwdA), 0);
      check("x0_stall", int'(oStallIF), 0);
      cyc();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc(); cyc();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("youngest_fwd", int'(oFwdA), 1); cyc();

      // branch with concurrent load-use
      drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); cyc();
      drive(1, 9, 1, 0, 0, 10, 1, 0, 1, 0);
      #1;
      check("br_flush", int'(oFlush), 1);
      check("br_no_stall", int'(oStallIF), 0);
      check("br_bubble", int'(oBubbleEX), 1);
      cyc();
      drive(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
      #1 check("br_flush2", int'(oFlush), 1); cyc();
      #1 check("br_flush3", int'(oFlush), 1); cyc();
      drive(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("br_flush_end", int'(oFlush), 0);
      check("br_killed_fwd", int'(oFwdA), 0);
      check("br_cnt", int'(oStallCnt), 1);
      cyc();

      // freeze with pending load-use and running flush counter
      drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0); cyc();
      drive(1, 0, 0, 12, 1, 0, 0, 0, 1, 1);
      #1;
      check("frz_stall", int'(oStallIF), 1);
      check("frz_flush", int'(oFlush), 1);
      cyc();
      drive(1, 0, 0, 12, 1, 0, 0, 0, 0, 1);
      repeat (3) begin
         #1;
         check("frz_hold_flush", int'(oFlush), 1);
         check("frz_hold_cnt", int'(oStallCnt), 1);
         cyc();
      end
      drive(1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
      repeat (4) cyc();

      // freeze on a plain load-use: no bubble until released
      drive(1, 0, 0, 0, 0, 13, 1, 1, 0, 0); cyc();
      drive(1, 0, 0, 13, 1, 0, 0, 0, 0, 1);
      #1;
      check("fz_stall", int'(oStallIF), 1);
      check("fz_bubble", int'(oBubbleEX), 0);
      cyc();
      drive(1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
      #1 check("fz_bubble_rel", int'(oBubbleEX), 1); cyc();
      #1 check("fz_cnt", int'(oStallCnt), 2); cyc();

      // asynchronous reset mid-run with live entries and active inputs
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cyc();
      drive(1, 5, 1, 5, 1, 6, 1, 1, 1, 0);
      #1 iRST = 1'b0;
      #1 check_all_zero("midrst");
      model_reset();
      @(posedge iCLK);
      @(negedge iCLK);
      #1 check_all_zero("midrst_hold");
      iRST = 1'b1;
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("midrst_fwd", int'(oFwdA), 0);
      cyc();

      // randomized traffic against the model
      repeat (2500) begin
         drive(int'($urandom_range(0, 7) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 11) == 0),
               int'($urandom_range(0, 7) == 0));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
